// File: rtl/coeff_fetch_sequencer_if.sv
// coeff_fetch_sequencer_if: control, bank and output-beat signals of the coefficient fetch sequencer.
// COEFF_SEQ_ABORT_EN adds the abort/aborted pair.
interface coeff_fetch_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int BUS_W  = 4096
) ();
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   num_rows;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ram_addr;
  logic [BUS_W-1:0]  ram_data;
  logic              out_valid;
  logic              out_ready;
  logic [BUS_W-1:0]  out_data;
  logic [ADDR_W-1:0] out_row;
  logic              out_last;
`ifdef COEFF_SEQ_ABORT_EN
  logic              abort;
  logic              aborted;
  modport master (
    input  start, base_addr, num_rows, ram_data, out_ready, abort,
    output busy, done, ram_addr, out_valid, out_data, out_row, out_last, aborted
  );
  modport slave (
    output start, base_addr, num_rows, ram_data, out_ready, abort,
    input  busy, done, ram_addr, out_valid, out_data, out_row, out_last, aborted
  );
`else
  modport master (
    input  start, base_addr, num_rows, ram_data, out_ready,
    output busy, done, ram_addr, out_valid, out_data, out_row, out_last
  );
  modport slave (
    output start, base_addr, num_rows, ram_data, out_ready,
    input  busy, done, ram_addr, out_valid, out_data, out_row, out_last
  );
`endif
endinterface

// File: rtl/coeff_fetch_sequencer.sv
// coeff_fetch_sequencer: one pass of shared-address bank reads into a 2-entry valid/ready FIFO.
// COEFF_SEQ_ABORT_EN enables the abort input and aborted pulse.
module coeff_fetch_sequencer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int BUS_W  = 4096
) (
  input logic clk,
  input logic rst,
  coeff_fetch_sequencer_if.master io_seq
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr, r_tag_row;
  logic [ADDR_W:0]   r_issued, r_total, w_sat;
  logic              r_inflight, r_tag_last;
  logic [BUS_W-1:0]  r_mem [2];
  logic [ADDR_W-1:0] r_mrow [2];
  logic [1:0]        r_mlast;
  logic              r_wp, r_rp;
  logic [1:0]        r_cnt;
  logic              w_valid, w_pop, w_issue, w_last, w_empty, w_abort;
  assign w_sat   = io_seq.num_rows > (ADDR_W+1)'(DEPTH) ? (ADDR_W+1)'(DEPTH) : io_seq.num_rows;
  assign w_valid = r_cnt != 2'd0;
  assign w_pop   = w_valid & io_seq.out_ready;
  assign w_last  = r_issued == r_total - 1'b1;
`ifdef COEFF_SEQ_ABORT_EN
  logic r_aborted;
  assign w_abort        = io_seq.abort & (r_state == RUN | r_state == DRAIN);
  assign io_seq.aborted = r_aborted;
  always_ff @(posedge clk) r_aborted <= rst ? 1'b0 : w_abort;
`else
  assign w_abort = 1'b0;
`endif
  // credit: entries held plus the read still returning, less what leaves this cycle
  assign w_issue = r_state == RUN && !w_abort && 3'(r_cnt) + 3'(r_inflight) - 3'(w_pop) < 3'd2;
  assign w_empty = !r_inflight && (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop));
  always_comb begin
    w_next = w_abort ? FINISH
           : r_state == IDLE  ? (io_seq.start ? (w_sat == '0 ? DRAIN : RUN) : IDLE)
           : r_state == RUN   ? (w_issue && w_last ? DRAIN : RUN)
           : r_state == DRAIN ? (w_empty ? FINISH : DRAIN)
           : IDLE;
    io_seq.busy = r_state == RUN || r_state == DRAIN;
    io_seq.done = r_state == FINISH;
  end
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_issued   <= '0;
      r_total    <= '0;
      r_inflight <= 1'b0;
      r_tag_row  <= '0;
      r_tag_last <= 1'b0;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_cnt      <= 2'd0;
    end else begin
      if (r_state == IDLE && io_seq.start) begin
        r_addr   <= io_seq.base_addr;
        r_issued <= '0;
        r_total  <= w_sat;
      end else if (w_issue) begin
        r_issued <= r_issued + 1'b1;
        r_addr   <= w_last ? r_addr : r_addr + 1'b1;
      end
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag_row  <= r_issued[ADDR_W-1:0];
        r_tag_last <= w_last;
      end
      if (w_abort) begin
        r_wp  <= 1'b0;
        r_rp  <= 1'b0;
        r_cnt <= 2'd0;
      end else begin
        r_wp  <= r_wp ^ r_inflight;
        r_rp  <= r_rp ^ w_pop;
        r_cnt <= r_cnt + 2'(r_inflight) - 2'(w_pop);
      end
    end
  end
  // bank data returns one cycle after the issue and is captured with its tag
  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_mem[r_wp]   <= io_seq.ram_data;
      r_mrow[r_wp]  <= r_tag_row;
      r_mlast[r_wp] <= r_tag_last;
    end
  end
  assign io_seq.ram_addr  = r_addr;
  assign io_seq.out_valid = w_valid;
  assign io_seq.out_data  = w_valid ? r_mem[r_rp] : '0;
  assign io_seq.out_row   = w_valid ? r_mrow[r_rp] : '0;
  assign io_seq.out_last  = w_valid & r_mlast[r_rp];
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(r_inflight && r_cnt == 2'd2 && !w_pop));
endmodule

// File: tb/tb_coeff_fetch_sequencer.sv
// tb_coeff_fetch_sequencer: vector table, random passes and reset/abort sequences against a row-queue model.
module tb_coeff_fetch_sequencer;
  localparam int DEPTH = 64, ADDR_W = 6, BUS_W = 128;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  coeff_fetch_sequencer_if #(.ADDR_W(ADDR_W), .BUS_W(BUS_W)) bus ();
  coeff_fetch_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BUS_W(BUS_W)) dut (.clk(clk), .rst(rst), .io_seq(bus));
  int checks = 0;
  int errors = 0;
  function automatic logic [BUS_W-1:0] bank(input int a);
    logic [31:0] w;
    w = 32'(a) * 32'h9E37_79B1 ^ 32'hC0EF_0000;
    return {w, ~w, w ^ 32'h1234_5678, 32'(a)};
  endfunction
  // synchronous bank array: every cycle returns the row addressed in the previous cycle
  always @(posedge clk) bus.ram_data <= bank(int'(bus.ram_addr));
  task automatic check(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_ram_addr"}, bus.ram_addr, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_out_row"}, bus.out_row, 0);
    check({tag, "_out_last"}, bus.out_last, 0);
`ifdef COEFF_SEQ_ABORT_EN
    check({tag, "_aborted"}, bus.aborted, 0);
`endif
  endtask
  typedef struct {
    logic [BUS_W-1:0]  data;
    logic [ADDR_W-1:0] row;
    logic              last;
  } beat_t;
  typedef struct {
    int base;
    int num;
    int pct;
    int exp_done;
    int restart;
  } vec_t;
  // called at a falling edge of an IDLE cycle; that cycle is cycle 0 of the pass
  task automatic run_pass(input int base, input int num, input int pct, input int exp_done, input int restart);
    int n;
    int last_hs;
    bit got_done, pv, pr;
    beat_t q[$];
    beat_t b, prev;
    n = num > DEPTH ? DEPTH : num;
    last_hs = -1;
    got_done = 0;
    pv = 0;
    pr = 0;
    for (int i = 0; i < n; i++) q.push_back('{bank((base + i) % DEPTH), ADDR_W'(i), i == n - 1});
    bus.start = 1'b1;
    bus.base_addr = ADDR_W'(base);
    bus.num_rows = (ADDR_W+1)'(num);
    for (int cyc = 0; cyc < 1000 && !got_done; cyc++) begin
      bus.out_ready = $urandom_range(99) < pct;
      if (cyc > 0) bus.start = cyc == restart;
      if (cyc == restart) begin
        bus.base_addr = ADDR_W'(base + 7);
        bus.num_rows = 7'd3;
      end
      if (cyc == 0) begin
        check("idle_busy", bus.busy, 0);
        check("idle_done", bus.done, 0);
      end
      if (cyc == 1) check("busy_after_start", bus.busy, 1);
      if (pct == 100 && cyc >= 1 && cyc <= n) check("ram_addr_issue", bus.ram_addr, (base + cyc - 1) % DEPTH);
      if (pv && !pr) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, prev.data);
        check("stall_row", bus.out_row, prev.row);
        check("stall_last", bus.out_last, prev.last);
      end
      if (bus.out_valid && q.size() == 0) check("extra_beat", bus.out_valid, 0);
      else if (bus.out_valid && bus.out_ready) begin
        b = q.pop_front();
        check("beat_data", bus.out_data, b.data);
        check("beat_row", bus.out_row, b.row);
        check("beat_last", bus.out_last, b.last);
        if (b.last) last_hs = cyc;
      end
      if (bus.done) begin
        got_done = 1;
        check("done_cycle", cyc, exp_done >= 0 ? exp_done : (n == 0 ? 2 : last_hs + 1));
        check("busy_at_done", bus.busy, 0);
      end
      pv = bus.out_valid;
      pr = bus.out_ready;
      prev = '{bus.out_data, bus.out_row, bus.out_last};
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("done_seen", got_done, 1);
    check("beats_missing", q.size(), 0);
  endtask
  task automatic run_until_row(input int base, input int num, input int row);
    bit found;
    found = 0;
    bus.start = 1'b1;
    bus.base_addr = ADDR_W'(base);
    bus.num_rows = (ADDR_W+1)'(num);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (bus.out_valid && int'(bus.out_row) == row) found = 1;
      else @(negedge clk);
    end
    check("row_reached", found, 1);
    @(negedge clk);
  endtask
  vec_t vecs[7];
  initial begin
    vecs[0] = '{0, 64, 100, 67, -1};
    vecs[1] = '{62, 4, 100, 7, -1};
    vecs[2] = '{5, 8, 30, -1, -1};
    vecs[3] = '{0, 0, 100, 2, -1};
    vecs[4] = '{33, 100, 100, 67, -1};
    vecs[5] = '{20, 10, 100, 13, 5};
    vecs[6] = '{40, 12, 50, -1, 4};
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.num_rows = '0;
    bus.out_ready = 1'b0;
`ifdef COEFF_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    foreach (vecs[i]) run_pass(vecs[i].base, vecs[i].num, vecs[i].pct, vecs[i].exp_done, vecs[i].restart);
    repeat (8) run_pass(int'($urandom_range(63)), int'($urandom_range(80)), int'($urandom_range(100, 20)), -1, -1);
    run_until_row(10, 20, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("midpass_reset");
    @(negedge clk);
    check("post_reset_valid", bus.out_valid, 0);
    check("post_reset_busy", bus.busy, 0);
    run_pass(3, 5, 100, 8, -1);
`ifdef COEFF_SEQ_ABORT_EN
    run_until_row(0, 64, 10);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_valid", bus.out_valid, 0);
    check("abort_done", bus.done, 1);
    check("abort_aborted", bus.aborted, 1);
    @(negedge clk);
    check("abort_idle_done", bus.done, 0);
    check("abort_idle_aborted", bus.aborted, 0);
    check("abort_idle_busy", bus.busy, 0);
    check("abort_idle_valid", bus.out_valid, 0);
    run_pass(8, 6, 100, 9, -1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
